// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction valid/ready handshake between fetch (master) and alu_ctrl_unit (slave)
interface alu_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  modport master (output instr, output instr_valid, input instr_ready);
  modport slave (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: 4-cycle sequencer decoding MSP430 double-operand words and driving a combinational ALU
// Ports: bus (instr/instr_valid/instr_ready), ld_en/ld_addr/ld_data register load in IDLE,
//   dbg_addr/dbg_data combinational register read, alu_a/alu_b/alu_sel to the ALU,
//   alu_result/alu_flags from the ALU, sr status {N,Z,C,V}, done/err one-cycle pulses.
// Macro ALU_CTRL_BYTE_MODE_EN enables B/W=1 byte operations; otherwise B/W=1 is illegal.
module alu_ctrl_unit #(
  parameter int NREGS = 16,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_ctrl_if.slave       bus,
  input  logic            ld_en,
  input  logic [3:0]      ld_addr,
  input  logic [DW-1:0]   ld_data,
  input  logic [3:0]      dbg_addr,
  output logic [DW-1:0]   dbg_data,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [4:0]      alu_sel,
  input  logic [DW-1:0]   alu_result,
  input  logic [3:0]      alu_flags,
  output logic [3:0]      sr,
  output logic            done,
  output logic            err
);
`ifdef ALU_CTRL_BYTE_MODE_EN
  localparam logic BYTE_EN = 1'b1;
`else
  localparam logic BYTE_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t        state_q;
  logic          ready_q, done_q, err_q, bw_q;
  logic [3:0]    op_q, src_q, dst_q, sr_q;
  logic [4:0]    sel_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [DW-1:0] regs_q [NREGS];
  logic          illegal_d, byte_d, wr_d;
  logic [4:0]    sel_d;
  logic [DW-1:0] opa_d, opb_d, res_d;
  logic [3:0]    flags_d;
  // legality is judged on the incoming word so err can be a registered pulse in DECODE
  assign illegal_d = (bus.instr[15:14] == 2'b00) | (|bus.instr[5:4]) | bus.instr[7] | (bus.instr[6] & ~BYTE_EN);
  assign byte_d = BYTE_EN & bw_q;
  // ALU select is opcode-4 except SUB and SUBC, which swap codes
  assign sel_d = op_q == 4'h7 ? 5'd4 : op_q == 4'h8 ? 5'd3 : {1'b0, op_q - 4'd4};
  assign opa_d = byte_d ? {{(DW-8){1'b0}}, regs_q[src_q][7:0]} : regs_q[src_q];
  assign opb_d = op_q == 4'h4 ? '0 : byte_d ? {{(DW-8){1'b0}}, regs_q[dst_q][7:0]} : regs_q[dst_q];
  assign res_d = byte_d ? {{(DW-8){1'b0}}, alu_result[7:0]} : alu_result;
  assign flags_d = byte_d ? {alu_result[7], alu_result[7:0] == 8'h00, alu_flags[1:0]} : alu_flags;
  assign wr_d = op_q != 4'h9 && op_q != 4'hB;
  assign bus.instr_ready = ready_q;
  assign dbg_data = regs_q[dbg_addr];
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_sel = sel_q;
  assign sr = sr_q;
  assign done = done_q;
  assign err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      bw_q <= 1'b0;
      op_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      sr_q <= '0;
      sel_q <= 5'b01100;
      alu_a_q <= '0;
      alu_b_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_en) regs_q[ld_addr] <= ld_data;
          if (bus.instr_valid) begin
            op_q <= bus.instr[15:12];
            src_q <= bus.instr[11:8];
            bw_q <= bus.instr[6];
            dst_q <= bus.instr[3:0];
            err_q <= illegal_d;
            ready_q <= 1'b0;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (err_q) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            alu_a_q <= opa_d;
            alu_b_q <= opb_d;
            sel_q <= sel_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          done_q <= 1'b1;
          state_q <= WB;
        end
        default: begin
          if (wr_d) regs_q[dst_q] <= res_d;
          if (op_q != 4'h4) sr_q <= flags_d;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: random and directed instruction stream checked against a register-file reference model
module tb_alu_ctrl_unit;
`ifdef ALU_CTRL_BYTE_MODE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [3:0] dbg_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] dbg_data, alu_a, alu_b, alu_result;
  logic [4:0] alu_sel;
  logic [3:0] alu_flags, sr;
  logic done, err;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_reg [16];
  logic [3:0] m_sr;
  logic [4:0] m_sel;
  logic [4:0] sel_tab [16] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd4,
                               5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
  always #5 clk = ~clk;
  alu_ctrl_if bus();
  alu_ctrl_unit dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .sr(sr), .done(done), .err(err)
  );
  // stand-in combinational ALU: {flags, result}
  function automatic logic [19:0] alu_fn(input logic [4:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    case (s)
      5'd0: t = {1'b0, a};
      5'd1, 5'd6: t = {1'b0, a} + {1'b0, b};
      5'd2: t = {1'b0, a} + {1'b0, b} + 17'd1;
      5'd3, 5'd5: t = {1'b0, b} - {1'b0, a};
      5'd4: t = {1'b0, b} - {1'b0, a} - 17'd1;
      5'd7, 5'd11: t = {1'b0, a & b};
      5'd8: t = {1'b0, ~a & b};
      5'd9: t = {1'b0, a | b};
      5'd10: t = {1'b0, a ^ b};
      default: t = '0;
    endcase
    r = t[15:0];
    return {r[15], r == 16'h0, t[16], a[15] ^ b[15] ^ r[15], r};
  endfunction
  assign {alu_flags, alu_result} = alu_fn(alu_sel, alu_a, alu_b);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_reg[r] = '0;
    m_sr = '0;
    m_sel = 5'b01100;
  endtask
  task automatic check_state(input string tag);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), 32'(dbg_data), 32'(m_reg[r]));
    end
    chk({tag, "_sr"}, 32'(sr), 32'(m_sr));
    chk({tag, "_sel"}, 32'(alu_sel), 32'(m_sel));
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
  endtask
  task automatic load(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
    m_reg[a] = v;
  endtask
  task automatic issue(input logic [15:0] i, input bit ld, input logic [3:0] la, input logic [15:0] lv, input bit late_ld);
    logic [3:0] op, s, d, f;
    logic [15:0] a, b, r;
    logic [19:0] o;
    logic legal;
    op = i[15:12];
    s = i[11:8];
    d = i[3:0];
    @(negedge clk);
    chk("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr = i;
    bus.instr_valid = 1'b1;
    ld_en = ld;
    ld_addr = la;
    ld_data = lv;
    if (ld) m_reg[la] = lv;
    legal = op >= 4'd4 && i[5:4] == 2'b00 && !i[7] && (!i[6] || BYTE_EN);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    ld_en = late_ld;
    ld_addr = 4'($urandom);
    ld_data = 16'($urandom);
    chk("err_decode", 32'(err), 32'(!legal));
    chk("ready_busy", 32'(bus.instr_ready), 32'd0);
    chk("done_decode", 32'(done), 32'd0);
    if (!legal) begin
      @(negedge clk);
      ld_en = 1'b0;
      chk("err_once", 32'(err), 32'd0);
      check_state("illegal");
    end else begin
      a = m_reg[s];
      b = op == 4'h4 ? 16'h0 : m_reg[d];
      if (i[6]) begin
        a = {8'h00, a[7:0]};
        b = {8'h00, b[7:0]};
      end
      m_sel = sel_tab[op];
      o = alu_fn(m_sel, a, b);
      f = o[19:16];
      r = o[15:0];
      if (i[6]) begin
        r = {8'h00, r[7:0]};
        f[3] = r[7];
        f[2] = r[7:0] == 8'h00;
      end
      if (op != 4'h9 && op != 4'hB) m_reg[d] = r;
      if (op != 4'h4) m_sr = f;
      @(negedge clk);
      ld_en = 1'b0;
      chk("exec_sel", 32'(alu_sel), 32'(m_sel));
      chk("exec_a", 32'(alu_a), 32'(a));
      chk("exec_b", 32'(alu_b), 32'(b));
      chk("done_exec", 32'(done), 32'd0);
      chk("err_exec", 32'(err), 32'd0);
      @(negedge clk);
      chk("done_wb", 32'(done), 32'd1);
      chk("ready_wb", 32'(bus.instr_ready), 32'd0);
      @(negedge clk);
      chk("done_after", 32'(done), 32'd0);
      check_state("retire");
    end
  endtask
  initial begin
    logic [15:0] i;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_a", 32'(alu_a), 32'd0);
    chk("rst_b", 32'(alu_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");
    load(4'd1, 16'h0003);
    load(4'd2, 16'h0004);
    issue(16'h5102, 1'b0, 4'd0, 16'h0, 1'b0);
    dbg_addr = 4'd2;
    #1;
    chk("add_r2", 32'(dbg_data), 32'h0007);
    load(4'd3, 16'hBEEF);
    issue(16'h4304, 1'b0, 4'd0, 16'h0, 1'b0);
    dbg_addr = 4'd4;
    #1;
    chk("mov_r4", 32'(dbg_data), 32'hBEEF);
    load(4'd1, 16'h0005);
    load(4'd2, 16'h0005);
    issue(16'h9102, 1'b0, 4'd0, 16'h0, 1'b0);
    issue(16'h1102, 1'b0, 4'd0, 16'h0, 1'b0);
    issue(16'h5112, 1'b0, 4'd0, 16'h0, 1'b0);
    issue(16'h5101, 1'b1, 4'd1, 16'h1234, 1'b1);
    load(4'd1, 16'h00FF);
    load(4'd2, 16'h1201);
    issue(16'h5142, 1'b0, 4'd0, 16'h0, 1'b0);
    dbg_addr = 4'd2;
    #1;
    chk("byte_r2", 32'(dbg_data), BYTE_EN ? 32'h0 : 32'h1201);
    for (int n = 0; n < 200; n++) begin
      i = 16'($urandom);
      if ($urandom_range(0, 3) != 0) i[7:4] = 4'h0;
      if ($urandom_range(0, 4) == 0) i[15:12] = 4'($urandom_range(0, 3));
      issue(i, $urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end
    load(4'd1, 16'h0003);
    load(4'd2, 16'h0004);
    @(negedge clk);
    bus.instr = 16'h5102;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    chk("midrst_a", 32'(alu_a), 32'd0);
    check_state("midrst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_unit.md
Name: alu_ctrl_unit

Overview:
- Sequencer that drives the 16-bit ALU: accepts MSP430-style double-operand instruction words over a valid/ready handshake.
- Decodes each instruction to the ALU 5-bit select, reads operands from an internal 16x16 register file, and presents them to the ALU.
- Captures the ALU result and {N,Z,C,V} flags, writes back, and maintains the status flags.
- Sits between instruction fetch and the ALU; the ALU itself stays combinational.

Parameters:
- NREGS, 16, register-file depth; fixed at 16 because instruction fields are 4 bits.
- DW, 16, datapath width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  16  instruction word: [15:12] opcode, [11:8] src, [7] Ad, [6] B/W, [5:4] As, [3:0] dst.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept an instruction.
- ld_en  in  1  register-file load strobe (init/test).
- ld_addr  in  4  load address.
- ld_data  in  16  load data.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of reg[dbg_addr].
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_sel  out  5  ALU select.
- alu_result  in  16  ALU result.
- alu_flags  in  4  ALU flags {N,Z,C,V}.
- sr  out  4  status flags {N,Z,C,V}.
- done  out  1  one-cycle pulse on retire.
- err  out  1  one-cycle pulse on illegal instruction.

Behaviour:
- Reset (async, any state): state IDLE, all registers 0x0000, sr=0, alu_a=alu_b=0, alu_sel=5'b01100, done=err=0, instr_ready=1 after reset release.
- FSM states:
  - IDLE: instr_ready=1; handshake occurs when instr_valid & instr_ready; instr latched; go to DECODE.
  - DECODE: legality check; read reg[src] and reg[dst] into operand latches. Legal -> EXEC. Illegal -> pulse err, no write, sr unchanged, -> IDLE.
  - EXEC: alu_sel/alu_a/alu_b driven from latches (alu_a=reg[src], alu_b=reg[dst]); -> WB.
  - WB: alu_result and alu_flags sampled this cycle; writeback and sr update at the closing edge; pulse done; -> IDLE.
- Latency: handshake at cycle 0, done high in cycle 3, register update visible in cycle 4. Throughput is one instruction per 4 cycles. instr_ready=0 outside IDLE.
- Opcode to alu_sel mapping:
  - 4 MOV -> 00000; alu_b forced to 0x0000.
  - 5 ADD -> 00001; 6 ADDC -> 00010; 7 SUBC -> 00100; 8 SUB -> 00011.
  - 9 CMP -> 00101; A DADD -> 00110; B BIT -> 00111.
  - C BIC -> 01000; D BIS -> 01001; E XOR -> 01010; F AND -> 01011.
- Illegal instructions:
  - Opcodes 0-3 (not double-operand).
  - As != 00 or Ad != 0 (only register mode is supported).
  - B/W=1 when byte mode is not compiled in.
- Writeback:
  - CMP and BIT: no register write.
  - All other opcodes: reg[dst] <= alu_result.
  - MOV: sr unchanged. Every other legal opcode: sr <= alu_flags.
  - src==dst is legal; both operands take the same register value.
- Load port:
  - ld_en writes reg[ld_addr] only in IDLE; ignored in other states.
  - ld_en coincident with a handshake: the load completes at that edge, so DECODE reads the loaded value.
- alu_sel holds its last value between instructions. It returns to 01100 only on reset.
- Reset mid-operation aborts the instruction: no done, no write, registers cleared.

Optional Feature:
- Macro ALU_CTRL_BYTE_MODE_EN.
- Defined: B/W=1 is legal. Operands are zero-extended from [7:0] before the ALU, and the written result is {8'h00, alu_result[7:0]}. sr <= alu_flags except N <= alu_result[7] and Z <= (alu_result[7:0]==0).
- Undefined: B/W=1 is illegal and produces an err pulse.

Test Plan:
- ADD: load R1=0x0003, R2=0x0004; instr 0x5102 -> done in cycle 3, R2=0x0007, alu_sel=00001 during EXEC, sr=alu_flags.
- MOV: load R3=0xBEEF, sr preset by a prior ADD; instr 0x4304 -> R4=0xBEEF, alu_b=0x0000 in EXEC, sr unchanged.
- CMP: R1=0x0005, R2=0x0005; instr 0x9102 -> R2 stays 0x0005, sr=alu_flags sampled in WB, done pulses.
- Illegal: instr 0x1102, then 0x5112 (As=01) -> err pulse in cycle 1 for each, no done, registers and sr unchanged, instr_ready back to 1 in cycle 2.
- Reset mid-op: issue 0x5102, assert rst in EXEC -> done never pulses, R2=0x0000, instr_ready=1 after release.
- Byte mode (macro defined): R1=0x00FF, R2=0x1201; instr 0x5142 -> R2=0x0000, Z=1. With the macro undefined -> err pulse, R2 stays 0x1201.
